db_read_drainer: RTL
====================

DB_READ_DRAINER -- requirements
Module: db_read_drainer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data path width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clk_en, input, 1 bit: global clock enable.
REQ-006 SHALL have port depth, input, 16 bits: words per frame; sampled at start.
REQ-007 SHALL have port start, input, 1 bit: frame request pulse.
REQ-008 SHALL have port ren_in, output, 1 bit: read enable to memory core.
REQ-009 SHALL have port data_out, input, DATA_W bits: read data from memory core.
REQ-010 SHALL have port valid_out, input, 1 bit: memory core read data valid.
REQ-011 SHALL have port out_data, output, DATA_W bits: downstream data.
REQ-012 SHALL have port out_valid, output, 1 bit: downstream valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.
REQ-016 SHALL have port err_orphan, output, 1 bit: sticky flag for unrequested valid_out.

Function
REQ-017 SHALL update all registers only when clk_en=1; ren_in SHALL be 0 while clk_en=0.
REQ-018 SHALL implement FSM states IDLE, ISSUE and DRAIN.
REQ-019 In IDLE, start=1 with depth!=0 SHALL latch depth, clear the issue count and enter ISSUE on the next cycle.
REQ-020 In IDLE, start=1 with depth=0 SHALL be ignored.
REQ-021 start in ISSUE or DRAIN SHALL be ignored.
REQ-022 ren_in SHALL be combinational and equal to (state==ISSUE && clk_en && credits>0).
REQ-023 credits SHALL equal FIFO_DEPTH - fifo_count - outstanding.
REQ-024 outstanding SHALL be +1 on ren_in, -1 on valid_out, unchanged on both together, and never exceed FIFO_DEPTH.
REQ-025 The cycle in which ren_in issues read number depth SHALL move the FSM to DRAIN; at most depth reads SHALL be issued per frame.
REQ-026 DRAIN SHALL go to IDLE and pulse frame_done for one cycle when outstanding=0 and the FIFO is empty.
REQ-027 valid_out=1 with outstanding=0 SHALL set err_orphan and drop data_out; the FIFO and counters SHALL be unchanged.
REQ-028 err_orphan SHALL be cleared only by reset.
REQ-029 valid_out with outstanding>0 SHALL push data_out into the FIFO; credits guarantee no overflow.
REQ-030 out_valid SHALL equal FIFO not empty.
REQ-031 out_data SHALL be the FIFO head and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-032 A pop SHALL occur on out_valid && out_ready && clk_en.
REQ-033 Push and pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-034 Delivery SHALL be in order, and with a memory read latency of L, ren_in-to-out_valid latency SHALL be L+1 cycles.
REQ-035 All 16-bit counters SHALL compare with equality only; they never wrap because depth <= 65535.

Reset
REQ-036 On reset=0, the block SHALL asynchronously set state=IDLE, clear the FIFO, outstanding and issue count, and set ren_in, out_valid, busy, frame_done and err_orphan to 0.
REQ-037 Reset mid-frame SHALL abandon the frame with no frame_done pulse; read data arriving after reset deasserts SHALL set err_orphan.
REQ-038 out_data SHALL be 0 after reset.

Structure
REQ-039 Package db_rd_pkg SHALL hold the state enum, DATA_W default, FIFO_DEPTH default and the count-width function clog2(FIFO_DEPTH+1).
REQ-040 The FIFO SHALL be a sub-module db_rd_fifo (push, pop, din, dout, count, empty) with the same clock and reset.
REQ-041 The top SHALL contain only the FSM, credit logic and error flag.

Verification
REQ-042 Scenario: depth=9, L=1, out_ready=1 -> 9 ren_in pulses, out_data sequence matches memory contents in order, exactly one frame_done, and busy falls the cycle after frame_done.
REQ-043 Scenario: depth=9, out_ready=0 -> exactly 4 ren_in pulses, then ren_in=0 with out_valid=1 and out_data held; raise out_ready -> remaining 5 reads issue, and exactly 9 words are delivered in total.
REQ-044 Scenario: valid_out=1 while IDLE -> err_orphan=1 and stays set; out_valid stays 0.
REQ-045 Scenario: clk_en toggled 1,0,1,0 during ISSUE -> ren_in is never high when clk_en=0; 9 words delivered, none duplicated.
REQ-046 Scenario: reset asserted after 3 reads of a depth=9 frame -> all outputs are 0 immediately; next start with depth=3 yields exactly 3 words and one frame_done.
REQ-047 Scenario: start held high across a frame, and start with depth=0 -> one frame only for the held start; no busy for the depth=0 start.

Source files
------------

// File: rtl/db_rd_pkg.sv
// db_rd_pkg: shared state encoding, parameter defaults and counter sizing for the read drainer.
package db_rd_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int DATA_W_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/db_rd_fifo.sv
// db_rd_fifo: power-of-two circular FIFO with the head presented combinationally on dout.
module db_rd_fifo
    import db_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int CW = cnt_w(DEPTH)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    assign empty = count == '0;
    // storage is cleared too so the head reads as zero out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/db_read_drainer.sv
// db_read_drainer: issues credit-limited memory reads per frame and drains the returned
// words in order through an output FIFO.
module db_read_drainer
    import db_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [15:0]       depth,
    input  logic              start,
    output logic              ren_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              valid_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              err_orphan
);
    localparam int CW = cnt_w(FIFO_DEPTH);
    state_t state, state_nxt;
    logic [15:0] depth_q, issued;
    logic [CW-1:0] outstanding, fifo_count, credits;
    logic start_d, fifo_empty, accept, pop, launch, last_read;

    assign credits = CW'(FIFO_DEPTH) - fifo_count - outstanding;
    assign ren_in = state == ISSUE && clk_en && credits != '0;
    assign accept = clk_en && valid_out && outstanding != '0;
    assign pop = out_valid && out_ready && clk_en;
    assign out_valid = !fifo_empty;
    assign busy = state != IDLE;
    // start is edge-qualified so a level held past the end of a frame cannot retrigger
    assign launch = start && !start_d && depth != '0;
    assign last_read = ren_in && issued + 16'd1 == depth_q;
    assign frame_done = clk_en && state == DRAIN && outstanding == '0 && fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = launch ? ISSUE : IDLE;
            ISSUE:   state_nxt = last_read ? DRAIN : ISSUE;
            DRAIN:   state_nxt = frame_done ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else if (clk_en) state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_d <= 1'b0;
            depth_q <= '0;
            issued <= '0;
            outstanding <= '0;
            err_orphan <= 1'b0;
        end else if (clk_en) begin
            start_d <= start;
            if (state == IDLE && launch) begin
                depth_q <= depth;
                issued <= '0;
            end else if (ren_in) begin
                issued <= issued + 16'd1;
            end
            outstanding <= outstanding + CW'(ren_in) - CW'(accept);
            if (valid_out && outstanding == '0) err_orphan <= 1'b1;
        end
    end

    db_rd_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (data_out),
        .dout  (out_data),
        .count (fifo_count),
        .empty (fifo_empty)
    );
endmodule
